// File: rtl/fc_stream_engine.sv
// Fully-connected layer engine: streams LANES activation/weight pairs per cycle,
// accumulates one neuron per row, then quantises and writes it as a single byte.
module fc_stream_engine #(
   parameter int DATA_WIDTH        = 8,
   parameter int WEIGHT_WIDTH      = 4,
   parameter int LANES             = 20,
   parameter int IN_LEN            = 800,
   parameter int OUT_LEN           = 500,
   parameter int ACC_WIDTH         = 24,
   parameter int ACT_ADDR_WIDTH    = 10,
   parameter int WEIGHT_ADDR_WIDTH = 15,
   parameter int OUT_ADDR_WIDTH    = 10
) (
   input  logic                            clk,
   input  logic                            srstn,
   input  logic                            start,
   input  logic [WEIGHT_ADDR_WIDTH-1:0]    weight_base,
   input  logic [3:0]                      shift,
   input  logic                            relu_en,
   output logic [ACT_ADDR_WIDTH-1:0]       sram_raddr_act,
   input  logic [LANES*DATA_WIDTH-1:0]     sram_rdata_act,
   output logic [WEIGHT_ADDR_WIDTH-1:0]    sram_raddr_weight,
   input  logic [LANES*WEIGHT_WIDTH-1:0]   sram_rdata_weight,
   output logic                            sram_wsb,
   output logic [3:0]                      sram_bytemask,
   output logic [OUT_ADDR_WIDTH-1:0]       sram_waddr,
   output logic [4*DATA_WIDTH-1:0]         sram_wdata,
   output logic                            busy,
   output logic                            done
);

   localparam int CHUNKS = IN_LEN / LANES;
   localparam int CW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
   localparam int NW = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;
   localparam logic [CW-1:0] K_LAST = CW'(CHUNKS - 1);
   localparam logic [NW-1:0] N_LAST = NW'(OUT_LEN - 1);
   localparam logic signed [ACC_WIDTH:0] Q_MAX = (ACC_WIDTH+1)'((1 << (DATA_WIDTH-1)) - 1);
   localparam logic signed [ACC_WIDTH:0] Q_MIN = -Q_MAX - (ACC_WIDTH+1)'(1);
   localparam logic [DATA_WIDTH-1:0] BYTE_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0] BYTE_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RUN   = 3'd1,
      DRAIN = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t state, state_d;

   logic [CW-1:0]                k;
   logic [NW-1:0]                n;
   logic [WEIGHT_ADDR_WIDTH-1:0] row;
   logic [WEIGHT_ADDR_WIDTH-1:0] base_r;
   logic [3:0]                   shift_r;
   logic                         relu_r;
   logic signed [ACC_WIDTH-1:0]  acc;
   logic signed [ACC_WIDTH-1:0]  dot;
   logic                         vld;
   logic                         first;

   always_ff @(posedge clk) begin
      if (!srstn) state <= IDLE;
      else        state <= state_d;
   end

   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (k == K_LAST) state_d = DRAIN;
         DRAIN:   state_d = WRITE;
         WRITE:   state_d = (n == N_LAST) ? DONE : RUN;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Read data lags the address by one cycle, so the MAC runs one cycle behind RUN.
   always_ff @(posedge clk) begin
      if (!srstn) begin
         k       <= '0;
         n       <= '0;
         row     <= '0;
         base_r  <= '0;
         shift_r <= '0;
         relu_r  <= 1'b0;
         acc     <= '0;
         vld     <= 1'b0;
         first   <= 1'b0;
      end else begin
         vld   <= (state == RUN);
         first <= (state == RUN) && (k == '0);
         if (vld) acc <= first ? dot : acc + dot;
         case (state)
            IDLE: if (start) begin
               base_r  <= weight_base;
               shift_r <= shift;
               relu_r  <= relu_en;
               k       <= '0;
               n       <= '0;
               row     <= '0;
               acc     <= '0;
            end
            RUN: if (k != K_LAST) k <= k + CW'(1);
            WRITE: begin
               k   <= '0;
               n   <= n + NW'(1);
               row <= row + WEIGHT_ADDR_WIDTH'(CHUNKS);
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      logic signed [DATA_WIDTH-1:0]   a_l;
      logic signed [WEIGHT_WIDTH-1:0] w_l;
      logic signed [ACC_WIDTH-1:0]    prod;
      dot  = '0;
      a_l  = '0;
      w_l  = '0;
      prod = '0;
      for (int i = 0; i < LANES; i++) begin
         a_l  = sram_rdata_act[i*DATA_WIDTH +: DATA_WIDTH];
         w_l  = sram_rdata_weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
         prod = a_l * w_l;
         dot  = dot + prod;
      end
   end

   // Round half up, then arithmetic shift; one guard bit keeps the rounding add from overflowing.
   logic signed [ACC_WIDTH:0] rnd;
   logic signed [ACC_WIDTH:0] biased;
   logic signed [ACC_WIDTH:0] shifted;
   logic [DATA_WIDTH-1:0]     q_byte;

   always_comb begin
      rnd     = (shift_r == 4'd0) ? '0 : ((ACC_WIDTH+1)'(1) << (shift_r - 4'd1));
      biased  = $signed({acc[ACC_WIDTH-1], acc}) + rnd;
      shifted = biased >>> shift_r;
      if (relu_r && shifted[ACC_WIDTH]) q_byte = '0;
      else if (shifted > Q_MAX)         q_byte = BYTE_MAX;
      else if (shifted < Q_MIN)         q_byte = BYTE_MIN;
      else                              q_byte = shifted[DATA_WIDTH-1:0];
   end

   logic [1:0] n_lo;
   assign n_lo = 2'(n);

   always_comb begin
      sram_raddr_act    = ACT_ADDR_WIDTH'(k);
      sram_raddr_weight = base_r + row + WEIGHT_ADDR_WIDTH'(k);
      busy              = (state == RUN) || (state == DRAIN) || (state == WRITE);
      done              = (state == DONE);
      sram_wsb          = 1'b1;
      sram_bytemask     = 4'hF;
      sram_waddr        = '0;
      sram_wdata        = '0;
      if (state == WRITE) begin
         sram_wsb      = 1'b0;
         sram_bytemask = ~(4'b1000 >> n_lo);
         sram_waddr    = OUT_ADDR_WIDTH'(n >> 2);
         sram_wdata    = {4{q_byte}};
      end
   end

endmodule
